// File: rtl/decode_queue.sv
// Purpose : RV32/RV64 IM pre-decode queue between fetch and issue; decodes at enqueue, stores DEPTH entries.
// Latency : an entry accepted in cycle N is presented at the head in cycle N+1 at the earliest (no bypass).
// Backpress: in_ready drops when full or flushing; out_valid holds the head until out_ready pops it.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard all entries and any same-cycle push
//   in_valid/in_ready     fetch handshake carrying in_pc, in_instr
//   out_valid/out_ready   issue handshake for the head entry
//   out_pc, out_instr     head pc and raw instruction
//   out_rd/rs1/rs2        register fields of the head instruction
//   out_ra1_en/ra2_en     head reads rs1 / rs2
//   out_reg_wen           head writes rd (never for rd==0)
//   out_cls               0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 MULDIV, 7 ILLEGAL
//   count                 occupancy
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int MEXT  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [63:0]                  in_pc,
    input  logic [31:0]                  in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_pc,
    output logic [31:0]                  out_instr,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic                         out_ra1_en,
    output logic                         out_ra2_en,
    output logic                         out_reg_wen,
    output logic [2:0]                   out_cls,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam bit RV64 = (XLEN == 64);
    localparam bit M_ON = (MEXT != 0);

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BRANCH  = 3'd3;
    localparam logic [2:0] CLS_JUMP    = 3'd4;
    localparam logic [2:0] CLS_MULDIV  = 3'd5;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic        ra1_en;
        logic        ra2_en;
        logic        wen;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    entry_t          w_entry;
    entry_t          w_head;

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_legal;
    logic [2:0]      w_cls;
    logic            w_ra1;
    logic            w_ra2;
    logic            w_wen;

    assign w_op = in_instr[6:0];
    assign w_f3 = in_instr[14:12];
    assign w_f7 = in_instr[31:25];

    // Decode the offered instruction; flags are set per opcode and then
    // cleared wholesale if the encoding turns out to be illegal.
    always_comb begin
        w_legal = 1'b0;
        w_cls   = CLS_ALU;
        w_ra1   = 1'b0;
        w_ra2   = 1'b0;
        w_wen   = 1'b0;
        case (w_op)
            7'b0110111, 7'b0010111: begin
                w_legal = 1'b1;
                w_wen   = 1'b1;
            end
            7'b1101111: begin
                w_legal = 1'b1;
                w_cls   = CLS_JUMP;
                w_wen   = 1'b1;
            end
            7'b1100111: begin
                w_legal = (w_f3 == 3'b000);
                w_cls   = CLS_JUMP;
                w_wen   = 1'b1;
                w_ra1   = 1'b1;
            end
            7'b1100011: begin
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_cls   = CLS_BRANCH;
                w_ra1   = 1'b1;
                w_ra2   = 1'b1;
            end
            7'b0000011: begin
                // LD (011) and LWU (110) only exist on RV64
                w_legal = (w_f3 != 3'b111) && (RV64 || ((w_f3 != 3'b011) && (w_f3 != 3'b110)));
                w_cls   = CLS_LOAD;
                w_wen   = 1'b1;
                w_ra1   = 1'b1;
            end
            7'b0100011: begin
                w_legal = !w_f3[2] && (RV64 || (w_f3 != 3'b011));
                w_cls   = CLS_STORE;
                w_ra1   = 1'b1;
                w_ra2   = 1'b1;
            end
            7'b0010011: begin
                w_wen = 1'b1;
                w_ra1 = 1'b1;
                // RV64 shifts borrow f7[0] as shamt[5]
                case (w_f3)
                    3'b001:  w_legal = RV64 ? (w_f7[6:1] == 6'b000000) : (w_f7 == 7'b0000000);
                    3'b101:  w_legal = RV64 ? ((w_f7[6:1] == 6'b000000) || (w_f7[6:1] == 6'b010000))
                                            : ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
                    default: w_legal = 1'b1;
                endcase
            end
            7'b0110011: begin
                w_wen = 1'b1;
                w_ra1 = 1'b1;
                w_ra2 = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_f7 == 7'b0100000) begin
                    w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                end else if (w_f7 == 7'b0000001) begin
                    w_legal = M_ON;
                    w_cls   = CLS_MULDIV;
                end
            end
            7'b0011011: begin
                w_wen   = 1'b1;
                w_ra1   = 1'b1;
                w_legal = RV64 && ((w_f3 == 3'b000) ||
                                   ((w_f3 == 3'b001) && (w_f7 == 7'b0000000)) ||
                                   ((w_f3 == 3'b101) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000))));
            end
            7'b0111011: begin
                w_wen = 1'b1;
                w_ra1 = 1'b1;
                w_ra2 = 1'b1;
                if (RV64) begin
                    if (w_f7 == 7'b0000000) begin
                        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101);
                    end else if (w_f7 == 7'b0100000) begin
                        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
                    end else if (w_f7 == 7'b0000001) begin
                        w_legal = M_ON && ((w_f3 == 3'b000) || w_f3[2]);
                        w_cls   = CLS_MULDIV;
                    end
                end
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_cls = CLS_ILLEGAL;
            w_ra1 = 1'b0;
            w_ra2 = 1'b0;
            w_wen = 1'b0;
        end
        if (in_instr[11:7] == 5'd0) begin
            w_wen = 1'b0;
        end
    end

    assign w_entry = '{pc: in_pc, instr: in_instr, cls: w_cls, ra1_en: w_ra1, ra2_en: w_ra2, wen: w_wen};

    assign in_ready  = (r_count < FULL) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign out_rd      = w_head.instr[11:7];
    assign out_rs1     = w_head.instr[19:15];
    assign out_rs2     = w_head.instr[24:20];
    assign out_ra1_en  = w_head.ra1_en;
    assign out_ra2_en  = w_head.ra2_en;
    assign out_reg_wen = w_head.wen;
    assign out_cls     = w_head.cls;
    assign count       = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Purpose : exercises decode_queue (RV64IM, RV32IM and RV64I variants fed the same stream).
// Latency : expected entries are queued at acceptance and checked when the head is popped.
// Backpress: stimulus waits on in_ready with a bounded cycle budget.
module tb_decode_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready, out_valid, ra1_en, ra2_en, reg_wen;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_cls;
    logic [2:0]  count;

    logic        a_in_ready, a_out_valid, a_ra1, a_ra2, a_wen;
    logic [63:0] a_pc;
    logic [31:0] a_instr;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_cls, a_count;

    logic        m_in_ready, m_out_valid, m_ra1, m_ra2, m_wen;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_cls, m_count;

    decode_queue #(.DEPTH(4), .XLEN(64), .MEXT(1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_ra1_en(ra1_en), .out_ra2_en(ra2_en), .out_reg_wen(reg_wen), .out_cls(out_cls), .count(count)
    );

    decode_queue #(.DEPTH(4), .XLEN(32), .MEXT(1)) u_d32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_instr(a_instr), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_ra1_en(a_ra1), .out_ra2_en(a_ra2), .out_reg_wen(a_wen), .out_cls(a_cls), .count(a_count)
    );

    decode_queue #(.DEPTH(4), .XLEN(64), .MEXT(0)) u_dm0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_pc), .out_instr(m_instr), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
        .out_ra1_en(m_ra1), .out_ra2_en(m_ra2), .out_reg_wen(m_wen), .out_cls(m_cls), .count(m_count)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [2:0]  cls;
        logic        ra1;
        logic        ra2;
        logic        wen;
        logic [2:0]  cls32;
        logic [2:0]  clsm0;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Offer one instruction and record its hand-computed decode once it is accepted.
    task automatic offer(input logic [63:0] pc, input logic [31:0] instr,
                         input logic [2:0] cls, input logic ra1, input logic ra2, input logic wen,
                         input logic [2:0] cls32, input logic [2:0] clsm0);
        exp_t e;
        int   n;
        bit   ok;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            e = '{pc: pc, instr: instr, cls: cls, ra1: ra1, ra2: ra2, wen: wen, cls32: cls32, clsm0: clsm0};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            total++;
            bad++;
            $display("FAIL offer_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (count != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every popped head against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc=%0h expected no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_instr", 64'(out_instr), 64'(e.instr));
                chk("pop_flags", 64'({out_cls, ra1_en, ra2_en, reg_wen}), 64'({e.cls, e.ra1, e.ra2, e.wen}));
                chk("pop_regs", 64'({out_rd, out_rs1, out_rs2}), 64'({e.instr[11:7], e.instr[19:15], e.instr[24:20]}));
                chk("pop_rv32", 64'({a_cls, a_wen}), 64'({e.cls32, (e.cls32 == 3'd7) ? 1'b0 : e.wen}));
                chk("pop_nomul", 64'({m_cls, m_wen}), 64'({e.clsm0, (e.clsm0 == 3'd7) ? 1'b0 : e.wen}));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // First entry visible the cycle after acceptance
        offer(64'h8000_0000, 32'h0050_0093, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0);
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_count", 64'(count), 64'd1);

        // Fill to DEPTH with out_ready low
        offer(64'h8000_0004, 32'h0020_8033, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        offer(64'h8000_0008, 32'h0020_A023, 3'd2, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2);
        offer(64'h8000_000C, 32'h0020_8063, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);

        fork
            offer(64'h8000_0010, 32'hFFFF_FFFF, 3'd7, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7);
            begin
                @(negedge clk);
                chk("held_in_ready", 64'(in_ready), 64'd0);
                chk("held_count", 64'(count), 64'd4);
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                chk("full_ready_no_push", 64'(in_ready), 64'd0);
                @(negedge clk);
                chk("ready_after_pop", 64'(in_ready), 64'd1);
            end
        join
        wait_empty();

        // Streaming push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            offer(64'h1000 + 64'(4 * i), 32'h0000_02B7 | (32'(i) << 12), 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
            chk("stream_count", 64'(count), 64'd1);
        end
        wait_empty();

        // Flush with a same-cycle offer
        out_ready = 1'b0;
        offer(64'h2000, 32'h0000_00EF, 3'd4, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4);
        offer(64'h2004, 32'h0001_00E7, 3'd4, 1'b1, 1'b0, 1'b1, 3'd4, 3'd4);
        offer(64'h2008, 32'h0000_A183, 3'd1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd1);
        chk("preflush_count", 64'(count), 64'd3);
        in_valid = 1'b1;
        in_pc    = 64'hDEAD;
        in_instr = 32'h0070_0093;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("postflush_count", 64'(count), 64'd0);
        chk("postflush_out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flushed_stays_empty", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Configuration-dependent legality
        out_ready = 1'b1;
        offer(64'h3000, 32'h0200_0033, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 3'd7);
        offer(64'h3004, 32'h0000_003B, 3'd0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd0);
        offer(64'h3008, 32'h4210_D093, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0);
        offer(64'h300C, 32'h0001_3083, 3'd1, 1'b1, 1'b0, 1'b1, 3'd7, 3'd1);
        wait_empty();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-fill
        out_ready = 1'b0;
        offer(64'h4000, 32'h0050_0093, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0);
        offer(64'h4004, 32'h0050_0093, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0);
        chk("prereset_count", 64'(count), 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
